// File: rtl/aes_io_pkg.sv
// Shared definitions for the AES byte input port.
// Contents:
//   state_t    - input-port FSM states (COLLECT / WAIT_CORE / SEND)
//   NUM_BYTES  - bytes per 128-bit AES block
//   NUM_WORDS  - 32-bit words per block handed to the core
//   GAP_W      - width of the inter-byte gap counter
//   blk_word() - selects 32-bit word idx of a block, word 0 = most significant
package aes_io_pkg;

    localparam int NUM_BYTES = 16;
    localparam int NUM_WORDS = 4;
    localparam int GAP_W     = 24;

    typedef enum logic [1:0] {
        ST_COLLECT   = 2'd0,
        ST_WAIT_CORE = 2'd1,
        ST_SEND      = 2'd2
    } state_t;

    function automatic logic [31:0] blk_word(input logic [8*NUM_BYTES-1:0] blk,
                                             input logic [1:0]             idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_sync_edge.sv
// Synchronizer and rising-edge detector for an asynchronous strobe.
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-low reset (clears every flop)
//   d_async    - asynchronous input
//   rise_pulse - one-cycle pulse per rising edge of d_async, after
//                SYNC_STAGES synchronizer flops
// A strobe that is already high when rst releases still produces one pulse,
// because the chain and the edge flop both restart from 0.
module aes_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   prev_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : gen_sync
            if (gi == 0) begin : gen_first
                assign sync_next[gi] = d_async;
            end else begin : gen_chain
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= sync_next;
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign rise_pulse = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/aes_inport.sv
// Byte-wide host input port that assembles 16 bytes into a 128-bit block and
// hands it to the AES core as four contiguous 32-bit words.
// Ports:
//   clk, rst    - system clock, asynchronous active-low reset
//   in_data     - host byte, captured on each synchronized strobe rising edge
//   in_strobe   - asynchronous host byte strobe
//   div_bits    - partial-frame timeout = 2^(div_bits+TO_BASE) idle cycles
//   core_ready  - core can accept a block
//   pass_data   - block word (first byte received is the MSB of word 0)
//   pass_valid  - word strobe, high for 4 consecutive cycles per block
//   in_ready    - high while bytes are being collected
//   overrun     - one-cycle pulse when a byte arrives outside COLLECT
//   timeout     - one-cycle pulse when a partial frame is discarded
// All outputs come straight from flops.
module aes_inport
    import aes_io_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TO_BASE     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_strobe,
    input  logic [3:0]  div_bits,
    input  logic        core_ready,
    output logic [31:0] pass_data,
    output logic        pass_valid,
    output logic        in_ready,
    output logic        overrun,
    output logic        timeout
);

    state_t                 state_reg;
    logic [3:0]             byte_cnt_reg;
    logic [1:0]             word_cnt_reg;
    logic [GAP_W-1:0]       gap_reg;
    logic [GAP_W-1:0]       gap_thr_m1;
    logic [8*NUM_BYTES-1:0] blk_reg;
    logic [8*NUM_BYTES-1:0] blk_next;
    logic                   byte_evt;
    logic                   blk_we;

    logic [31:0]            pass_data_reg;
    logic                   pass_valid_reg;
    logic                   in_ready_reg;
    logic                   overrun_reg;
    logic                   timeout_reg;

    aes_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .d_async   (in_strobe),
        .rise_pulse(byte_evt)
    );

    // Timeout is registered on the edge at which the gap counter becomes
    // 2^(div_bits+TO_BASE), so the pulse is visible while gap == threshold.
    assign gap_thr_m1 = (GAP_W'(1) << ({1'b0, div_bits} + 5'(TO_BASE))) - GAP_W'(1);

    assign blk_we = byte_evt && (state_reg == ST_COLLECT);

    // One write lane per byte position; byte k goes to the k-th byte from the top.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : gen_lane
            assign blk_next[8*(NUM_BYTES-1-gi) +: 8] =
                (blk_we && (byte_cnt_reg == 4'(gi))) ? in_data
                                                      : blk_reg[8*(NUM_BYTES-1-gi) +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_COLLECT;
            byte_cnt_reg   <= '0;
            word_cnt_reg   <= '0;
            gap_reg        <= '0;
            blk_reg        <= '0;
            pass_data_reg  <= '0;
            pass_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b1;
            overrun_reg    <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            timeout_reg <= 1'b0;
            blk_reg     <= blk_next;

            if (byte_evt) begin
                gap_reg <= '0;
            end else if (gap_reg != '1) begin
                gap_reg <= gap_reg + GAP_W'(1);
            end

            case (state_reg)
                ST_COLLECT: begin
                    // A byte on the threshold cycle wins over the timeout.
                    if (byte_evt) begin
                        byte_cnt_reg <= byte_cnt_reg + 4'd1;
                        if (byte_cnt_reg == 4'(NUM_BYTES-1)) begin
                            state_reg    <= ST_WAIT_CORE;
                            in_ready_reg <= 1'b0;
                        end
                    end else if ((byte_cnt_reg != 4'd0) && (gap_reg == gap_thr_m1)) begin
                        byte_cnt_reg <= '0;
                        timeout_reg  <= 1'b1;
                    end
                end

                ST_WAIT_CORE: begin
                    overrun_reg <= byte_evt;
                    if (core_ready) begin
                        state_reg      <= ST_SEND;
                        word_cnt_reg   <= '0;
                        pass_valid_reg <= 1'b1;
                        pass_data_reg  <= blk_word(blk_reg, 2'd0);
                    end
                end

                ST_SEND: begin
                    // core_ready is not looked at here: the block always goes out whole.
                    overrun_reg <= byte_evt;
                    if (word_cnt_reg == 2'(NUM_WORDS-1)) begin
                        state_reg      <= ST_COLLECT;
                        word_cnt_reg   <= '0;
                        pass_valid_reg <= 1'b0;
                        pass_data_reg  <= '0;
                        in_ready_reg   <= 1'b1;
                    end else begin
                        word_cnt_reg  <= word_cnt_reg + 2'd1;
                        pass_data_reg <= blk_word(blk_reg, word_cnt_reg + 2'd1);
                    end
                end

                default: begin
                    state_reg      <= ST_COLLECT;
                    byte_cnt_reg   <= '0;
                    word_cnt_reg   <= '0;
                    pass_valid_reg <= 1'b0;
                    pass_data_reg  <= '0;
                    in_ready_reg   <= 1'b1;
                end
            endcase
        end
    end

    assign pass_data  = pass_data_reg;
    assign pass_valid = pass_valid_reg;
    assign in_ready   = in_ready_reg;
    assign overrun    = overrun_reg;
    assign timeout    = timeout_reg;

endmodule

// File: tb/tb_aes_inport.sv
// Self-checking bench for aes_inport: table of full frames with hand-computed
// words, plus directed sequences for back-pressure, overrun, timeout,
// byte-on-timeout-cycle and reset during SEND.
module tb_aes_inport;

    localparam int SYNC = 2;
    localparam int TOB  = 8;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_strobe;
    logic [3:0]  div_bits;
    logic        core_ready;
    logic [31:0] pass_data;
    logic        pass_valid;
    logic        in_ready;
    logic        overrun;
    logic        timeout;

    aes_inport #(
        .SYNC_STAGES(SYNC),
        .TO_BASE    (TOB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_strobe (in_strobe),
        .div_bits  (div_bits),
        .core_ready(core_ready),
        .pass_data (pass_data),
        .pass_valid(pass_valid),
        .in_ready  (in_ready),
        .overrun   (overrun),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Monitor state
    logic [31:0] wq[$];
    int          wcyc[$];
    int          ocount = 0;
    int          tcount = 0;
    int          tcyc   = 0;
    int          zero_viol = 0;
    int          last_raise = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (pass_valid) begin
                wq.push_back(pass_data);
                wcyc.push_back(cyc);
            end else if (pass_data != 32'h0) begin
                zero_viol++;
            end
            if (overrun) ocount++;
            if (timeout) begin
                tcount++;
                tcyc = cyc;
            end
        end
    end

    typedef struct packed {
        logic [127:0] stream;   // first byte sent is the leftmost byte
        logic [31:0]  w0;
        logic [31:0]  w1;
        logic [31:0]  w2;
        logic [31:0]  w3;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Caller is just after a posedge; strobe high 4 cycles, low 4 cycles.
    task automatic strobe_body(input logic [7:0] b);
        in_data    = b;
        in_strobe  = 1'b1;
        last_raise = cyc;
        repeat (4) @(posedge clk);
        #1 in_strobe = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        strobe_body(b);
    endtask

    task automatic send_frame(input logic [127:0] s, input int first, input int last);
        logic [127:0] t;
        t = s;
        for (int k = first; k <= last; k++) send_byte(t[127-8*k -: 8]);
    endtask

    task automatic wait_words(input int n, input int budget);
        int k;
        k = 0;
        while (wq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        #1;
        if (wq.size() < n) begin
            total++;
            bad++;
            $display("FAIL wait_words: got %0d words, required %0d", wq.size(), n);
        end
    endtask

    task automatic check_words(input string nm, input vec_t v);
        wait_words(4, 40);
        if (wq.size() >= 4) begin
            $display("frame %s: %h %h %h %h", nm, wq[0], wq[1], wq[2], wq[3]);
            chk({nm, "_w0"}, wq[0], v.w0);
            chk({nm, "_w1"}, wq[1], v.w1);
            chk({nm, "_w2"}, wq[2], v.w2);
            chk({nm, "_w3"}, wq[3], v.w3);
            chk({nm, "_contig"}, wcyc[3] - wcyc[0], 32'd3);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_pass_data"},  pass_data,  32'h0);
        chk({nm, "_pass_valid"}, pass_valid, 32'h0);
        chk({nm, "_in_ready"},   in_ready,   32'h1);
        chk({nm, "_overrun"},    overrun,    32'h0);
        chk({nm, "_timeout"},    timeout,    32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int viol;
        int k;

        vecs[0] = '{stream: 128'h00112233_44556677_8899AABB_CCDDEEFF,
                    w0: 32'h00112233, w1: 32'h44556677, w2: 32'h8899AABB, w3: 32'hCCDDEEFF};
        vecs[1] = '{stream: 128'h01020304_05060708_090A0B0C_0D0E0F10,
                    w0: 32'h01020304, w1: 32'h05060708, w2: 32'h090A0B0C, w3: 32'h0D0E0F10};
        vecs[2] = '{stream: 128'hFFFEFDFC_FBFAF9F8_F7F6F5F4_F3F2F1F0,
                    w0: 32'hFFFEFDFC, w1: 32'hFBFAF9F8, w2: 32'hF7F6F5F4, w3: 32'hF3F2F1F0};
        vecs[3] = '{stream: 128'hDEADBEEF_01234567_89ABCDEF_00000080,
                    w0: 32'hDEADBEEF, w1: 32'h01234567, w2: 32'h89ABCDEF, w3: 32'h00000080};

        rst        = 1'b0;
        in_data    = 8'h00;
        in_strobe  = 1'b0;
        div_bits   = 4'd2;
        core_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b1;

        // Table of full frames with core_ready high
        for (int i = 0; i < 4; i++) begin
            wq.delete();
            wcyc.delete();
            send_frame(vecs[i].stream, 0, 15);
            check_words($sformatf("vec%0d", i), vecs[i]);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i), in_ready, 32'h1);
        end

        // Core not ready for 50 cycles after a full frame
        wq.delete();
        wcyc.delete();
        core_ready = 1'b0;
        send_frame(vecs[1].stream, 0, 15);
        viol = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || pass_valid !== 1'b0) viol++;
        end
        chk("hold_in_ready", in_ready, 32'h0);
        chk("hold_violations", viol, 32'h0);
        core_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("send_after_ready_valid", pass_valid, 32'h1);
        chk("send_after_ready_data", pass_data, vecs[1].w0);
        check_words("backpressure", vecs[1]);

        // 17th byte during WAIT_CORE
        wq.delete();
        wcyc.delete();
        core_ready = 1'b0;
        send_frame(vecs[2].stream, 0, 15);
        ocount = 0;
        send_byte(8'h77);
        repeat (5) @(posedge clk);
        chk("overrun_pulse_cycles", ocount, 32'h1);
        core_ready = 1'b1;
        check_words("overrun", vecs[2]);
        repeat (4) @(posedge clk);

        // Timeout after 5 bytes with div_bits=0
        div_bits = 4'd0;
        wq.delete();
        wcyc.delete();
        tcount = 0;
        send_frame(vecs[3].stream, 0, 4);
        repeat (300) @(posedge clk);
        chk("timeout_count", tcount, 32'h1);
        chk("timeout_gap", tcyc - last_raise, 32'(SYNC + 1 + 256));
        send_frame(vecs[2].stream, 0, 15);
        check_words("after_timeout", vecs[2]);
        chk("timeout_count_after", tcount, 32'h1);
        repeat (4) @(posedge clk);

        // Byte event lands exactly on the timeout cycle
        wq.delete();
        wcyc.delete();
        tcount = 0;
        send_byte(vecs[1].stream[127:120]);
        k = last_raise + 256;
        do begin
            @(posedge clk);
            #1;
        end while (cyc < k);
        strobe_body(vecs[1].stream[119:112]);
        send_frame(vecs[1].stream, 2, 15);
        check_words("edge_timeout", vecs[1]);
        chk("edge_timeout_count", tcount, 32'h0);
        repeat (4) @(posedge clk);
        div_bits = 4'd2;

        // Reset asserted in SEND cycle 1
        wq.delete();
        wcyc.delete();
        send_frame(vecs[3].stream, 0, 14);
        @(posedge clk);
        #1;
        in_data   = vecs[3].stream[7:0];
        in_strobe = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (pass_valid !== 1'b1 && k < 20);
        chk("rst_send_started", pass_valid, 32'h1);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_strobe = 1'b0;
        #1;
        check_reset_outputs("rst_in_send");
        @(posedge clk);
        @(posedge clk);
        #1;
        // Strobe already high at reset release counts as the first byte.
        in_data   = vecs[0].stream[127:120];
        in_strobe = 1'b1;
        rst       = 1'b1;
        repeat (4) @(posedge clk);
        #1 in_strobe = 1'b0;
        repeat (16) @(posedge clk);
        chk("no_valid_after_rst", wq.size(), 32'h1);
        wq.delete();
        wcyc.delete();
        send_frame(vecs[0].stream, 1, 15);
        check_words("after_rst", vecs[0]);

        chk("zero_when_idle", zero_viol, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
